// File: rtl/ro_puf_measure_ctrl_if.sv
// Bundle between the RO-PUF measurement sequencer, its counter pair and the readout.
// PUF_MARGIN_EN adds the per-bit unstable flags.
interface ro_puf_measure_ctrl_if #(
  parameter int NUM_BITS = 32,
  parameter int SEL_W    = 5
);
  logic                start;
  logic                busy;
  logic                done;
  logic                err;
  logic [NUM_BITS-1:0] resp;
  logic                resp_valid;
`ifdef PUF_MARGIN_EN
  logic [NUM_BITS-1:0] unstable;
`endif
  logic [SEL_W-1:0]    sel;
  logic                cnt_clr;
  logic                cnt_en;
  logic                clr_done_a;
  logic                clr_done_b;
  logic [31:0]         cnt_a;
  logic [31:0]         cnt_b;

`ifdef PUF_MARGIN_EN
  modport slave (
    input  start, clr_done_a, clr_done_b,
    input  cnt_a, cnt_b,
    output busy, done, err, resp, resp_valid,
    output unstable, sel, cnt_clr, cnt_en
  );
  modport master (
    output start, clr_done_a, clr_done_b,
    output cnt_a, cnt_b,
    input  busy, done, err, resp, resp_valid,
    input  unstable, sel, cnt_clr, cnt_en
  );
`else
  modport slave (
    input  start, clr_done_a, clr_done_b,
    input  cnt_a, cnt_b,
    output busy, done, err, resp, resp_valid,
    output sel, cnt_clr, cnt_en
  );
  modport master (
    output start, clr_done_a, clr_done_b,
    output cnt_a, cnt_b,
    input  busy, done, err, resp, resp_valid,
    input  sel, cnt_clr, cnt_en
  );
`endif
endinterface

// File: rtl/ro_puf_measure_ctrl.sv
// RO-PUF measurement sequencer: clear, gate, settle, compare per bit.
// Optional PUF_MARGIN_EN flags bits whose count difference is below MARGIN.
module ro_puf_measure_ctrl #(
  parameter int NUM_BITS    = 32,
  parameter int SEL_W       = 5,
  parameter int WINDOW      = 1024,
  parameter int SETTLE      = 4,
`ifdef PUF_MARGIN_EN
  parameter int MARGIN      = 8,
`endif
  parameter int CLR_TIMEOUT = 16
) (
  input logic                   clk,
  input logic                   rst,
  ro_puf_measure_ctrl_if.slave  bus_io
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLEAR  = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_COUNT  = 3'd3;
  localparam logic [2:0] S_SETTLE = 3'd4;
  localparam logic [2:0] S_CMP    = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  localparam int TM1  = (WINDOW > SETTLE) ? WINDOW : SETTLE;
  localparam int TMAX = (TM1 > CLR_TIMEOUT) ? TM1 : CLR_TIMEOUT;
  localparam int TW   = $clog2(TMAX + 1);

  logic [2:0]          state_q, state_d;
  logic [TW-1:0]       tmr_q, tmr_d;
  logic [SEL_W-1:0]    idx_q, idx_d;
  logic [NUM_BITS-1:0] resp_q, resp_d;
  logic                err_q, err_d;
  logic                rv_q, rv_d;
  logic                busy_q, done_q;
  logic                clr_q, en_q;
  logic                a_gt_b;

  assign a_gt_b = bus_io.cnt_a > bus_io.cnt_b;

`ifdef PUF_MARGIN_EN
  logic [NUM_BITS-1:0] unst_q, unst_d;
  logic [32:0]         diff;
  logic [32:0]         mag;
  logic                close;

  // 33-bit difference keeps the sign of cnt_a - cnt_b exact
  assign diff  = {1'b0, bus_io.cnt_a} - {1'b0, bus_io.cnt_b};
  assign mag   = diff[32] ? (~diff + 33'd1) : diff;
  assign close = mag < 33'(MARGIN);
`endif

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    idx_d   = idx_q;
    resp_d  = resp_q;
    err_d   = err_q;
    rv_d    = rv_q;
`ifdef PUF_MARGIN_EN
    unst_d  = unst_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (bus_io.start) begin
          resp_d  = '0;
          err_d   = 1'b0;
          rv_d    = 1'b0;
          idx_d   = '0;
`ifdef PUF_MARGIN_EN
          unst_d  = '0;
`endif
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: state_d = S_WAIT;
      S_WAIT: begin
        if (bus_io.clr_done_a && bus_io.clr_done_b) begin
          state_d = S_COUNT;
        end else if (tmr_q == TW'(CLR_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      S_COUNT: begin
        if (tmr_q == TW'(WINDOW - 1)) state_d = S_SETTLE;
        else tmr_d = tmr_q + 1'b1;
      end
      S_SETTLE: begin
        if (tmr_q == TW'(SETTLE - 1)) state_d = S_CMP;
        else tmr_d = tmr_q + 1'b1;
      end
      S_CMP: begin
        resp_d[idx_q] = a_gt_b;
`ifdef PUF_MARGIN_EN
        unst_d[idx_q] = close;
`endif
        if (idx_q == SEL_W'(NUM_BITS - 1)) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_CLEAR;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // every state entry starts its timer from zero
    if (state_d != state_q) tmr_d = '0;
    if (state_d == S_DONE) rv_d = ~err_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      tmr_q   <= '0;
      idx_q   <= '0;
      resp_q  <= '0;
      err_q   <= 1'b0;
      rv_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      clr_q   <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      idx_q   <= idx_d;
      resp_q  <= resp_d;
      err_q   <= err_d;
      rv_q    <= rv_d;
      busy_q  <= state_d != S_IDLE;
      done_q  <= state_d == S_DONE;
      clr_q   <= state_d == S_CLEAR;
      en_q    <= state_d == S_COUNT;
    end
  end

`ifdef PUF_MARGIN_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) unst_q <= '0;
    else     unst_q <= unst_d;
  end
  assign bus_io.unstable = unst_q;
`endif

  assign bus_io.busy       = busy_q;
  assign bus_io.done       = done_q;
  assign bus_io.err        = err_q;
  assign bus_io.resp       = resp_q;
  assign bus_io.resp_valid = rv_q;
  assign bus_io.sel        = idx_q;
  assign bus_io.cnt_clr    = clr_q;
  assign bus_io.cnt_en     = en_q;

endmodule

// File: doc/ro_puf_measure_ctrl.md
Name: ro_puf_measure_ctrl

Overview:
- Measurement sequencer for the ring-oscillator PUF, one stage upstream of the pair of standard 32-bit counters.
- For each response bit it:
  - selects an oscillator pair;
  - clears both counters and waits for their clear-done flags;
  - gates counting for a fixed window, lets the counts settle, then compares them.
- Builds an NUM_BITS-wide response word and hands it to the key/readout logic with a start/done handshake.

Parameters:
- NUM_BITS, 32, response bits per measurement run; also the number of oscillator pairs.
- SEL_W, 5, width of the pair-select output; must satisfy 2**SEL_W >= NUM_BITS.
- WINDOW, 1024, number of cycles cnt_en is held high per bit; must be >= 1.
- SETTLE, 4, idle cycles after the window before comparing; must be >= 1.
- CLR_TIMEOUT, 16, maximum cycles to wait for both clear-done flags.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  starts a run; sampled only in IDLE.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a run ends, with or without error.
- err  out  1  clear-timeout flag; valid with done; held until next accepted start.
- resp  out  NUM_BITS  response word; bit i comes from pair i.
- resp_valid  out  1  high from done until the next accepted start; low if err.
- sel  out  SEL_W  oscillator pair select, equal to the current bit index.
- cnt_clr  out  1  clear strobe to both counters.
- cnt_en  out  1  count enable to both counters.
- clr_done_a  in  1  clear-done flag from counter A.
- clr_done_b  in  1  clear-done flag from counter B.
- cnt_a  in  32  count from counter A.
- cnt_b  in  32  count from counter B.

Behaviour:
- Reset values, asserted at any time including mid-run: state=IDLE; busy, done, err, resp_valid, cnt_clr, cnt_en = 0; resp=0; sel=0; internal bit index and timers = 0.
- All outputs are registered.
- States: IDLE, CLEAR, WAIT_CLR, COUNT, SETTLE, COMPARE, DONE.
- IDLE:
  - With start=1: clear resp, err and resp_valid; set bit index = 0 and sel = 0; go to CLEAR.
  - start is ignored in all other states.
- CLEAR: cnt_clr=1 for exactly one cycle, then go to WAIT_CLR.
- WAIT_CLR:
  - Hold cnt_clr=0 and cnt_en=0.
  - When clr_done_a && clr_done_b, go to COUNT and load the window timer.
  - If both are not seen within CLR_TIMEOUT cycles of entering this state, set err=1 and go to DONE.
- COUNT: cnt_en=1 for exactly WINDOW consecutive cycles, then go to SETTLE.
- SETTLE: cnt_en=0 for SETTLE cycles, so the final increments are visible on cnt_a/cnt_b; then go to COMPARE.
- COMPARE (one cycle):
  - Compute resp[idx] = (cnt_a > cnt_b), unsigned. A tie gives 0.
  - If idx == NUM_BITS-1, go to DONE.
  - Otherwise increment idx and sel, then go to CLEAR.
- DONE (one cycle):
  - done=1; resp_valid=1 unless err.
  - Go to IDLE; resp and resp_valid hold until the next accepted start.
- Per-bit latency: 1 (CLEAR) + W (WAIT_CLR cycles) + WINDOW + SETTLE + 1 (COMPARE).
- Run latency: the per-bit latency summed over all bits, plus 1 for DONE.
- cnt_clr and cnt_en are never high in the same cycle.
- Counter wrap-around is not detected; WINDOW must keep counts below 2**32.
- start asserted in the DONE cycle is ignored; it is accepted the next cycle in IDLE if still high.

Optional Feature:
- Macro: PUF_MARGIN_EN.
- When defined:
  - Adds parameter MARGIN, default 8.
  - Adds output port unstable [NUM_BITS-1:0], reset 0, cleared on accepted start.
  - In COMPARE, compute a 33-bit signed difference cnt_a - cnt_b. unstable[idx] = 1 when its absolute value < MARGIN; resp[idx] is still written normally.
  - unstable is valid under the same rule as resp.
- When undefined: the unstable port and margin logic are absent; all other behaviour is identical.

Test Plan:
Bench parameters: NUM_BITS=4, WINDOW=8, SETTLE=2, CLR_TIMEOUT=4. Counter models clear in 1 cycle.
- Basic run: start pulse; counter A runs at 2x the rate of counter B for pairs 0 and 2, and at half rate for pairs 1 and 3 -> resp=4'b0101, done one cycle, resp_valid=1, err=0, sel steps 0,1,2,3, cnt_en high exactly 8 cycles per bit.
- Tie: cnt_a=cnt_b=40 for all pairs -> resp=4'b0000; with PUF_MARGIN_EN and MARGIN=8, unstable=4'b1111.
- Clear timeout: clr_done_b held 0 -> err=1 and done 4 cycles after entering WAIT_CLR; resp_valid=0; cnt_en never asserted.
- Reset mid-run: assert rst during COUNT of bit 2 -> all outputs 0 immediately (asynchronous); a new start then yields a full 4-bit run.
- Start while busy: pulse start during SETTLE of bit 1 -> ignored, run completes normally, exactly one done pulse.
- Margin: with PUF_MARGIN_EN, cnt_a=100 and cnt_b=95 on pair 0 -> resp[0]=1, unstable[0]=1; cnt_a=100 and cnt_b=80 -> unstable[0]=0.
